// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer.
// Owns the fetch PC, reads a combinational instruction memory, and buffers
// {instruction, pc} pairs in a small circular FIFO handed to decode over a
// valid/ready handshake. Stops on an all-zero word (end of program image),
// accepts redirects, and locks up on a misaligned redirect target.
//
// Ports:
//   clk, reset          clock (rising edge), asynchronous active-low reset
//   fetch_en            level enable for fetching
//   imem_addr           byte address presented to instruction memory (= PC)
//   imem_instr          word returned combinationally for imem_addr
//   redirect_valid/pc   one-cycle redirect request and its byte target
//   if_valid/ready      head-of-FIFO handshake with decode
//   if_instr/if_pc      head instruction word and its byte address
//   done                end-of-program reached
//   misalign_err        misaligned redirect seen; cleared only by reset
module fetch_ctrl #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned IMEM_BYTES = 32,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        fetch_en,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_instr,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        if_valid,
   input  logic        if_ready,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc,
   output logic        done,
   output logic        misalign_err
);

   localparam int unsigned     PtrW     = $clog2(FIFO_DEPTH);
   localparam int unsigned     CntW     = PtrW + 1;
   localparam logic [CntW-1:0] DepthCnt = CntW'(FIFO_DEPTH);
   // IMEM_BYTES is a power of two, so modulo is a mask.
   localparam logic [31:0]     PcMask   = 32'(IMEM_BYTES - 1);

   typedef enum logic [1:0] {StIdle, StRun, StDone, StError} state_e;

   state_e          state_q, state_d;
   logic [31:0]     pc_q, pc_d;
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0] count_q, count_d;
   logic [31:0]     instr_mem_q [FIFO_DEPTH];
   logic [31:0]     instr_mem_d [FIFO_DEPTH];
   logic [31:0]     pc_mem_q    [FIFO_DEPTH];
   logic [31:0]     pc_mem_d    [FIFO_DEPTH];

   logic enq;
   logic deq;
   logic flush;
   logic space;

   assign if_valid     = (count_q != '0);
   assign deq          = if_valid && if_ready;
   // A full FIFO still has room if the head leaves this cycle.
   assign space        = (count_q < DepthCnt) || deq;
   assign if_instr     = instr_mem_q[rd_ptr_q];
   assign if_pc        = pc_mem_q[rd_ptr_q];
   assign imem_addr    = pc_q;
   assign done         = (state_q == StDone);
   assign misalign_err = (state_q == StError);

   // Sequencing: state, PC, and the enqueue/flush decisions.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      enq     = 1'b0;
      flush   = 1'b0;
      if (redirect_valid && (state_q != StError)) begin
         flush = 1'b1;
         if (redirect_pc[1:0] != 2'b00) begin
            state_d = StError;
         end else begin
            pc_d    = redirect_pc & PcMask;
            state_d = fetch_en ? StRun : StIdle;
         end
      end else begin
         unique case (state_q)
            StIdle: begin
               if (fetch_en) state_d = StRun;
            end
            StRun: begin
               if (!fetch_en) begin
                  state_d = StIdle;
               end else if (space) begin
                  if (imem_instr != 32'h0) begin
                     enq  = 1'b1;
                     pc_d = (pc_q + 32'd4) & PcMask;
                  end else begin
                     // End of image: PC stays on the zero word.
                     state_d = StDone;
                  end
               end
            end
            StDone:  ;
            StError: ;
         endcase
      end
   end

   // FIFO bookkeeping. A head handshake in a flush cycle is still a completed
   // transfer; the flush then discards whatever remains. Storage is not
   // cleared on flush.
   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      instr_mem_d = instr_mem_q;
      pc_mem_d    = pc_mem_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (enq) begin
            instr_mem_d[wr_ptr_q] = imem_instr;
            pc_mem_d[wr_ptr_q]    = pc_q;
            wr_ptr_d              = wr_ptr_q + PtrW'(1);
         end
         if (deq) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
         end
         count_d = count_q + CntW'(enq) - CntW'(deq);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= StIdle;
         pc_q        <= RESET_PC;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         instr_mem_q <= '{default: '0};
         pc_mem_q    <= '{default: '0};
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         instr_mem_q <= instr_mem_d;
         pc_mem_q    <= pc_mem_d;
      end
   end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Testbench for fetch_ctrl: directed vector table, hand-written corner
// sequences, then randomized stimulus checked against a queue-based model.
module tb_fetch_ctrl;

   localparam int unsigned IMEM_BYTES = 32;
   localparam int unsigned DEPTH      = 2;
   localparam logic [31:0] SKIP       = 32'hFFFF_FFFF;

   localparam int M_IDLE = 0;
   localparam int M_RUN  = 1;
   localparam int M_DONE = 2;
   localparam int M_ERR  = 3;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        fetch_en = 1'b0;
   logic [31:0] imem_addr;
   logic [31:0] imem_instr;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        if_valid;
   logic        if_ready = 1'b0;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic        done;
   logic        misalign_err;

   logic [31:0] mem [8];

   int checks = 0;
   int errors = 0;

   // Reference model state
   int          m_mode;
   logic [31:0] m_pc;
   logic [63:0] mq [$];

   typedef struct {
      logic        fe;
      logic        rdy;
      logic        rv;
      logic [31:0] rpc;
      logic        v;
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] addr;
      logic        dn;
      logic        er;
   } vec_t;

   vec_t tbl [$];

   fetch_ctrl #(
      .RESET_PC  (32'h0),
      .IMEM_BYTES(IMEM_BYTES),
      .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .fetch_en      (fetch_en),
      .imem_addr     (imem_addr),
      .imem_instr    (imem_instr),
      .redirect_valid(redirect_valid),
      .redirect_pc   (redirect_pc),
      .if_valid      (if_valid),
      .if_ready      (if_ready),
      .if_instr      (if_instr),
      .if_pc         (if_pc),
      .done          (done),
      .misalign_err  (misalign_err)
   );

   always #5 clk = ~clk;

   assign imem_instr = mem[imem_addr[4:2]];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic fe, input logic rdy, input logic rv,
                               input logic [31:0] rpc, input logic v, input logic [31:0] pc,
                               input logic [31:0] instr, input logic [31:0] addr,
                               input logic dn, input logic er);
      vec_t r;
      r.fe = fe; r.rdy = rdy; r.rv = rv; r.rpc = rpc; r.v = v;
      r.pc = pc; r.instr = instr; r.addr = addr; r.dn = dn; r.er = er;
      return r;
   endfunction

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_addr"},  imem_addr, 32'h0);
      chk({tag, "_valid"}, {31'h0, if_valid}, 32'h0);
      chk({tag, "_instr"}, if_instr, 32'h0);
      chk({tag, "_pc"},    if_pc, 32'h0);
      chk({tag, "_done"},  {31'h0, done}, 32'h0);
      chk({tag, "_err"},   {31'h0, misalign_err}, 32'h0);
   endtask

   // Hold reset across one edge, release 1 time unit after an edge.
   task automatic do_reset();
      reset = 1'b0;
      fetch_en = 1'b0;
      if_ready = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc = 32'h0;
      @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      mq.delete();
      m_pc = 32'h0;
      m_mode = M_IDLE;
   endtask

   // One clock of behaviour, evaluated from the inputs present before the edge.
   task automatic model_step();
      logic [63:0] ent;
      logic [31:0] w;
      if (mq.size() != 0 && if_ready) ent = mq.pop_front();
      if (m_mode != M_ERR && redirect_valid) begin
         mq.delete();
         if (redirect_pc[1:0] != 2'b00) begin
            m_mode = M_ERR;
         end else begin
            m_pc = redirect_pc % IMEM_BYTES;
            m_mode = fetch_en ? M_RUN : M_IDLE;
         end
      end else if (m_mode == M_IDLE) begin
         if (fetch_en) m_mode = M_RUN;
      end else if (m_mode == M_RUN) begin
         if (!fetch_en) begin
            m_mode = M_IDLE;
         end else if (mq.size() < DEPTH) begin
            w = mem[int'(m_pc / 4)];
            if (w != 32'h0) begin
               mq.push_back({w, m_pc});
               m_pc = (m_pc + 4) % IMEM_BYTES;
            end else begin
               m_mode = M_DONE;
            end
         end
      end
   endtask

   task automatic model_compare();
      chk("rnd_valid", {31'h0, if_valid}, {31'h0, mq.size() != 0});
      chk("rnd_addr",  imem_addr, m_pc);
      chk("rnd_done",  {31'h0, done}, {31'h0, m_mode == M_DONE});
      chk("rnd_err",   {31'h0, misalign_err}, {31'h0, m_mode == M_ERR});
      if (mq.size() != 0) begin
         chk("rnd_instr", if_instr, mq[0][63:32]);
         chk("rnd_pc",    if_pc,    mq[0][31:0]);
      end
   endtask

   initial begin
      mem[0] = 32'hFFC4A303; mem[1] = 32'h0064A423; mem[2] = 32'h0062E233;
      mem[3] = 32'h00A00093; mem[4] = 32'h00100113; mem[5] = 32'h002081B3;
      mem[6] = 32'h00000000; mem[7] = 32'hFFF00213;

      //                fe rdy rv rpc       v  pc     instr         addr   dn er
      tbl.push_back(mk(1, 0, 0, 32'h0,  0, 32'h0,  32'h0,        32'h0,  0, 0));
      tbl.push_back(mk(1, 0, 0, 32'h0,  1, 32'h0,  32'hFFC4A303, 32'h4,  0, 0));
      tbl.push_back(mk(1, 0, 0, 32'h0,  1, 32'h0,  32'hFFC4A303, 32'h8,  0, 0));
      tbl.push_back(mk(1, 0, 0, 32'h0,  1, 32'h0,  32'hFFC4A303, 32'h8,  0, 0));
      tbl.push_back(mk(1, 0, 0, 32'h0,  1, 32'h0,  32'hFFC4A303, 32'h8,  0, 0));
      tbl.push_back(mk(1, 0, 0, 32'h0,  1, 32'h0,  32'hFFC4A303, 32'h8,  0, 0));
      tbl.push_back(mk(1, 1, 0, 32'h0,  1, 32'h4,  32'h0064A423, 32'hC,  0, 0));
      tbl.push_back(mk(1, 1, 0, 32'h0,  1, 32'h8,  32'h0062E233, 32'h10, 0, 0));
      tbl.push_back(mk(1, 1, 1, 32'h10, 0, 32'h0,  32'h0,        32'h10, 0, 0));
      tbl.push_back(mk(1, 1, 0, 32'h0,  1, 32'h10, 32'h00100113, 32'h14, 0, 0));
      tbl.push_back(mk(1, 1, 0, 32'h0,  1, 32'h14, 32'h002081B3, 32'h18, 0, 0));
      tbl.push_back(mk(1, 1, 0, 32'h0,  0, 32'h0,  32'h0,        32'h18, 1, 0));
      tbl.push_back(mk(1, 1, 0, 32'h0,  0, 32'h0,  32'h0,        32'h18, 1, 0));
      tbl.push_back(mk(1, 1, 1, 32'h4,  0, 32'h0,  32'h0,        32'h4,  0, 0));
      tbl.push_back(mk(1, 1, 0, 32'h0,  1, 32'h4,  32'h0064A423, 32'h8,  0, 0));
      tbl.push_back(mk(1, 1, 1, 32'h1C, 0, 32'h0,  32'h0,        32'h1C, 0, 0));
      tbl.push_back(mk(1, 1, 0, 32'h0,  1, 32'h1C, 32'hFFF00213, 32'h0,  0, 0));
      tbl.push_back(mk(1, 1, 0, 32'h0,  1, 32'h0,  32'hFFC4A303, 32'h4,  0, 0));
      tbl.push_back(mk(1, 1, 1, 32'h6,  0, 32'h0,  32'h0,        SKIP,   0, 1));
      tbl.push_back(mk(1, 1, 1, 32'h4,  0, 32'h0,  32'h0,        SKIP,   0, 1));
      tbl.push_back(mk(1, 1, 0, 32'h0,  0, 32'h0,  32'h0,        SKIP,   0, 1));

      // Reset values while reset is held.
      #2;
      chk_reset_vals("rst");

      // Directed table: buffering, redirect with handshake, done, wrap, error.
      do_reset();
      for (int i = 0; i < tbl.size(); i++) begin
         fetch_en       = tbl[i].fe;
         if_ready       = tbl[i].rdy;
         redirect_valid = tbl[i].rv;
         redirect_pc    = tbl[i].rpc;
         step();
         chk($sformatf("tbl%0d_valid", i), {31'h0, if_valid}, {31'h0, tbl[i].v});
         chk($sformatf("tbl%0d_done", i),  {31'h0, done}, {31'h0, tbl[i].dn});
         chk($sformatf("tbl%0d_err", i),   {31'h0, misalign_err}, {31'h0, tbl[i].er});
         if (tbl[i].addr != SKIP) chk($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].addr);
         if (tbl[i].v) begin
            chk($sformatf("tbl%0d_pc", i),    if_pc, tbl[i].pc);
            chk($sformatf("tbl%0d_instr", i), if_instr, tbl[i].instr);
         end
      end

      // fetch_en dropped with a full FIFO: contents retained, fetching stops.
      do_reset();
      fetch_en = 1'b1;
      repeat (3) step();
      fetch_en = 1'b0;
      step();
      chk("idle_valid", {31'h0, if_valid}, 32'h1);
      chk("idle_pc",    if_pc, 32'h0);
      chk("idle_addr",  imem_addr, 32'h8);
      if_ready = 1'b1;
      step();
      chk("idle_drain_pc",   if_pc, 32'h4);
      chk("idle_drain_addr", imem_addr, 32'h8);
      step();
      chk("idle_empty", {31'h0, if_valid}, 32'h0);

      // Asynchronous reset mid-run: outputs clear without a clock edge.
      do_reset();
      fetch_en = 1'b1;
      if_ready = 1'b0;
      repeat (4) step();
      chk("pre_async_valid", {31'h0, if_valid}, 32'h1);
      #2;
      reset = 1'b0;
      #1;
      chk_reset_vals("async");
      @(posedge clk);
      #1;
      reset = 1'b1;

      // Randomized stimulus against the model.
      for (int r = 0; r < 6; r++) begin
         for (int k = 0; k < 8; k++) begin
            mem[k] = ($urandom_range(0, 7) == 0) ? 32'h0 : ($urandom | 32'h1);
         end
         do_reset();
         model_reset();
         for (int c = 0; c < 300; c++) begin
            fetch_en       = ($urandom_range(0, 9) != 0);
            if_ready       = ($urandom_range(0, 2) != 0);
            redirect_valid = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 39) == 0) redirect_pc = $urandom | 32'h2;
            else redirect_pc = $urandom & ~32'h3;
            model_step();
            step();
            model_compare();
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
